// File: rtl/ram_loadable.sv
// Loadable RAM: asynchronous-read memory with a post-reset zero-clear sequence
// and a PROG-mode streaming loader (valid/ready, auto-incrementing pointer).
module ram_loadable #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              RI,
  output logic [DATA_W-1:0] DOUT,
  input  logic              PROG,
  input  logic              LD_VALID,
  output logic              LD_READY,
  output logic [ADDR_W-1:0] LD_PTR,
  output logic              LD_DONE,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              done_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_clear;
  logic              in_run;
  logic              in_load;
  logic              clear_last;
  logic              ptr_last;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign in_clear   = (state_reg == ST_CLEAR);
  assign in_run     = (state_reg == ST_RUN);
  assign in_load    = (state_reg == ST_LOAD);
  assign clear_last = &cnt_reg;
  assign ptr_last   = &ptr_reg;

  // Single write port shared by the clear sweep, RUN writes and the loader.
  always_comb begin
    we    = 1'b0;
    waddr = ADDR;
    wdata = DIN;
    if (!RESET) begin
      if (in_clear) begin
        we    = 1'b1;
        waddr = cnt_reg;
        wdata = '0;
      end else if (in_load) begin
        we    = LD_VALID;
        waddr = ptr_reg;
      end else if (in_run) begin
        we    = RI;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_RESET;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          cnt_reg <= cnt_reg + ADDR_W'(1);
          if (clear_last) begin
            state_reg <= PROG ? ST_LOAD : ST_RUN;
          end
        end
        ST_RUN: begin
          if (PROG) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= '0;
            done_reg  <= 1'b0;
          end
        end
        ST_LOAD: begin
          // LD_READY is 1 here, so a valid word completes even on the PROG=0 edge.
          if (LD_VALID) begin
            ptr_reg <= ptr_reg + ADDR_W'(1);
            if (ptr_last) begin
              done_reg <= 1'b1;
            end
          end
          if (!PROG) begin
            state_reg <= ST_RUN;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign BUSY     = RESET ? CLEAR_ON_RESET : in_clear;
  assign LD_READY = !RESET && in_load;
  assign LD_PTR   = RESET ? '0 : ptr_reg;
  assign LD_DONE  = !RESET && done_reg;
  assign DOUT     = (RESET || in_clear) ? '0 : mem[ADDR];

endmodule
